// File: rtl/imem_fetch_responder.sv
// imem_fetch_responder
//   Instruction-memory responder for the fetch stage. A PC request is accepted
//   over a valid/ready handshake and read from a wait-stated memory. The read
//   has a fixed latency of LATENCY cycles. Responses drain through a small
//   first-word-fallthrough FIFO, so fetch can stall without losing data.
//   A redirect flush discards everything that is outstanding. A loader port
//   preloads program words; it may be used during reset or while fetch is idle.
//
//   Optional build macro: IMEM_PARITY_EN
//     Keeps one even-parity bit per word and adds the ld_perr_inj input. When a
//     read finds a parity mismatch, the response is faulted and returns a NOP.
//
//   Ports
//     clk, rst                 rising-edge clock, synchronous active-high reset
//     req_valid/req_ready      PC request handshake; req_addr is the byte PC
//     flush                    redirect, drops all in-flight and queued work
//     rsp_valid/rsp_ready      response handshake
//     rsp_data/rsp_addr        instruction word and the PC it belongs to
//     rsp_fault                misaligned, out-of-range or parity-failed read
//     ld_we/ld_addr/ld_data    loader write port (word addressed by ld_addr[31:2])
//     ld_perr_inj              (IMEM_PARITY_EN only) store inverted parity
module imem_fetch_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        flush,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [31:0] rsp_addr,
  output logic        rsp_fault,
  input  logic        ld_we,
  input  logic [31:0] ld_addr,
`ifdef IMEM_PARITY_EN
  input  logic        ld_perr_inj,
`endif
  input  logic [31:0] ld_data
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int FW = $clog2(FIFO_DEPTH);
  localparam int CW = FW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  // Storage
  logic [31:0] mem [DEPTH_WORDS];
`ifdef IMEM_PARITY_EN
  logic        memPar [DEPTH_WORDS];
`endif

  // Request decode
  logic [AW-1:0] reqIdx;
  logic          reqFault;
  logic          accept;
  logic [CW-1:0] outstanding;

  assign reqIdx    = req_addr[AW+1:2];
  assign reqFault  = (req_addr[1:0] != 2'b00) ||
                     ({1'b0, req_addr[31:2]} >= 31'(DEPTH_WORDS));
  assign req_ready = !rst && !flush && !ld_we && (outstanding < CW'(FIFO_DEPTH));
  assign accept    = req_valid && req_ready;

  // Loader write
  logic [AW-1:0] ldIdx;
  logic          ldInRange;
  logic          unusedLdLow;

  assign ldIdx       = ld_addr[AW+1:2];
  assign ldInRange   = {1'b0, ld_addr[31:2]} < 31'(DEPTH_WORDS);
  assign unusedLdLow = ^ld_addr[1:0];

  always_ff @(posedge clk) begin
    if (ld_we && ldInRange) begin
      mem[ldIdx] <= ld_data;
`ifdef IMEM_PARITY_EN
      memPar[ldIdx] <= (^ld_data) ^ ld_perr_inj;
`endif
    end
  end

  // Read pipeline: stage 0 holds the synchronous memory read and the
  // later stages only add wait states.
  logic [LATENCY-1:0] vld_p;
  logic [31:0]        addr_p  [LATENCY];
  logic [31:0]        word_p  [LATENCY];
  logic               fault_p [LATENCY];
`ifdef IMEM_PARITY_EN
  logic               par_p   [LATENCY];
`endif

  // ---- stage 0: capture request, read memory (skipped for faulted PCs) ----
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_p[0]  <= req_addr;
      fault_p[0] <= reqFault;
      if (!reqFault) begin
        word_p[0] <= mem[reqIdx];
`ifdef IMEM_PARITY_EN
        par_p[0]  <= memPar[reqIdx];
`endif
      end
    end
    // ---- stages 1..LATENCY-1: wait states ----
    for (int s = 1; s < LATENCY; s++) begin
      addr_p[s]  <= addr_p[s-1];
      word_p[s]  <= word_p[s-1];
      fault_p[s] <= fault_p[s-1];
`ifdef IMEM_PARITY_EN
      par_p[s]   <= par_p[s-1];
`endif
    end
  end

  // ---- pipeline exit: resolve fault (address or parity) into final data ----
  logic        lastVld;
  logic        lastPerr;
  logic        lastFault;
  logic [31:0] lastData;

  assign lastVld = vld_p[LATENCY-1];
`ifdef IMEM_PARITY_EN
  assign lastPerr = (^word_p[LATENCY-1]) ^ par_p[LATENCY-1];
`else
  assign lastPerr = 1'b0;
`endif
  assign lastFault = fault_p[LATENCY-1] || lastPerr;
  assign lastData  = lastFault ? NOP : word_p[LATENCY-1];

  // Response FIFO. An entry leaving the pipeline bypasses the FIFO when the
  // FIFO is empty and fetch takes it in the same cycle. Otherwise it is written
  // at the tail; the head is then the same entry, so a stalled output is stable.
  logic [31:0]   fifoData  [FIFO_DEPTH];
  logic [31:0]   fifoAddr  [FIFO_DEPTH];
  logic          fifoFault [FIFO_DEPTH];
  logic [FW-1:0] wrPtr;
  logic [FW-1:0] rdPtr;
  logic [CW-1:0] fifoCount;
  logic          fifoEmpty;
  logic          fifoPush;
  logic          fifoPop;
  logic          rspPop;

  assign fifoEmpty = (fifoCount == '0);
  assign rsp_valid = !fifoEmpty || lastVld;
  assign rspPop    = rsp_valid && rsp_ready;
  assign fifoPop   = !fifoEmpty && rsp_ready;
  assign fifoPush  = lastVld && !(fifoEmpty && rsp_ready);

  always_ff @(posedge clk) begin
    if (fifoPush) begin
      fifoData[wrPtr]  <= lastData;
      fifoAddr[wrPtr]  <= addr_p[LATENCY-1];
      fifoFault[wrPtr] <= lastFault;
    end
  end

  always_comb begin
    rsp_data  = '0;
    rsp_addr  = '0;
    rsp_fault = 1'b0;
    if (!fifoEmpty) begin
      rsp_data  = fifoData[rdPtr];
      rsp_addr  = fifoAddr[rdPtr];
      rsp_fault = fifoFault[rdPtr];
    end else if (lastVld) begin
      rsp_data  = lastData;
      rsp_addr  = addr_p[LATENCY-1];
      rsp_fault = lastFault;
    end
  end

  // Control state. Reset and flush both discard all outstanding work. A pop
  // in the flush cycle is dropped along with everything else.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      vld_p       <= '0;
      wrPtr       <= '0;
      rdPtr       <= '0;
      fifoCount   <= '0;
      outstanding <= '0;
    end else begin
      vld_p[0] <= accept;
      for (int s = 1; s < LATENCY; s++) begin
        vld_p[s] <= vld_p[s-1];
      end
      if (fifoPush) wrPtr <= wrPtr + 1'b1;
      if (fifoPop)  rdPtr <= rdPtr + 1'b1;
      fifoCount   <= fifoCount + CW'(fifoPush) - CW'(fifoPop);
      outstanding <= outstanding + CW'(accept) - CW'(rspPop);
    end
  end

endmodule

// File: tb/tb_imem_fetch_responder.sv
module tb_imem_fetch_responder;

  localparam int DEPTH_WORDS = 1024;
  localparam int LATENCY     = 2;
  localparam int FIFO_DEPTH  = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        flush;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [31:0] rsp_addr;
  logic        rsp_fault;
  logic        ld_we;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;
  logic        ld_perr_inj;

  imem_fetch_responder #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .LATENCY    (LATENCY),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .flush      (flush),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_addr   (rsp_addr),
    .rsp_fault  (rsp_fault),
    .ld_we      (ld_we),
    .ld_addr    (ld_addr),
`ifdef IMEM_PARITY_EN
    .ld_perr_inj(ld_perr_inj),
`endif
    .ld_data    (ld_data)
  );

  always #5 clk = ~clk;

  int nCmp = 0;
  int nErr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %08h expected %08h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the set of outstanding requests is an ordered queue.
  // Each entry becomes visible LATENCY cycles after its accept cycle.
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        fault;
    int          readyAt;
  } rsp_t;

  rsp_t        pend[$];
  logic [31:0] mMem [DEPTH_WORDS];
  bit          mBad [DEPTH_WORDS];
  int          cyc = 0;

  function automatic rsp_t makeRsp(input logic [31:0] a);
    rsp_t r;
    int unsigned w;
    bit oor;
    w   = a[31:2];
    oor = (w >= DEPTH_WORDS);
    r.addr    = a;
    r.fault   = (a[1:0] != 2'b00) || oor || (!oor && mBad[w]);
    r.data    = r.fault ? NOP : mMem[w];
    r.readyAt = cyc + LATENCY;
    return r;
  endfunction

  // One clock: check outputs against the model, clock, advance the model.
  task automatic step();
    bit eRdy;
    bit eVld;
    int unsigned lw;
    #1;
    eRdy = !rst && !flush && !ld_we && (pend.size() < FIFO_DEPTH);
    eVld = (pend.size() > 0) && (pend[0].readyAt <= cyc);
    chk("m_req_ready", 32'(req_ready), 32'(eRdy));
    chk("m_rsp_valid", 32'(rsp_valid), 32'(eVld));
    if (eVld) begin
      chk("m_rsp_addr",  rsp_addr, pend[0].addr);
      chk("m_rsp_data",  rsp_data, pend[0].data);
      chk("m_rsp_fault", 32'(rsp_fault), 32'(pend[0].fault));
    end
    @(posedge clk);
    if (rst || flush) begin
      pend.delete();
    end else begin
      if (eVld && rsp_ready) void'(pend.pop_front());
      if (req_valid && eRdy) pend.push_back(makeRsp(req_addr));
    end
    lw = ld_addr[31:2];
    if (ld_we && lw < DEPTH_WORDS) begin
      mMem[lw] = ld_data;
`ifdef IMEM_PARITY_EN
      mBad[lw] = ld_perr_inj;
`else
      mBad[lw] = 1'b0;
`endif
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic idleInputs();
    rst = 0; flush = 0; req_valid = 0; req_addr = 0; rsp_ready = 1;
    ld_we = 0; ld_addr = 0; ld_data = 0; ld_perr_inj = 0;
  endtask

  // Directed vectors: one record per cycle, expected outputs worked out by hand.
  typedef struct {
    logic        rv;
    logic [31:0] ra;
    logic        rr;
    logic        fl;
    logic        we;
    logic [31:0] la;
    logic [31:0] ld;
    logic        eRdy;
    logic        eVld;
    logic [31:0] eAddr;
    logic [31:0] eData;
    logic        eFault;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rv, input logic [31:0] ra, input logic fl,
                              input logic we, input logic [31:0] la, input logic [31:0] ld,
                              input logic eRdy, input logic eVld, input logic [31:0] eAddr,
                              input logic [31:0] eData, input logic eFault);
    vec_t v;
    v.rv = rv; v.ra = ra; v.rr = 1'b1; v.fl = fl; v.we = we; v.la = la; v.ld = ld;
    v.eRdy = eRdy; v.eVld = eVld; v.eAddr = eAddr; v.eData = eData; v.eFault = eFault;
    return v;
  endfunction

  initial begin
    logic [31:0] held;
    int accCnt;

    for (int i = 0; i < DEPTH_WORDS; i++) begin
      mMem[i] = '0;
      mBad[i] = 1'b0;
    end

    // Load phase
    vecs.push_back(mk(0, 0, 0, 1, 32'h00, 32'h00500093, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 32'h04, 32'h00A00113, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 32'h08, 32'h002081B3, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 32'h0C, 32'h00000013, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 32'h40, 32'h12345678, 0, 0, 0, 0, 0));
    // Back-to-back fetch, latency 2
    vecs.push_back(mk(1, 32'h0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 32'h4, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 32'h8, 0, 0, 0, 0, 1, 1, 32'h0, 32'h00500093, 0));
    vecs.push_back(mk(1, 32'hC, 0, 0, 0, 0, 1, 1, 32'h4, 32'h00A00113, 0));
    vecs.push_back(mk(0, 0,     0, 0, 0, 0, 1, 1, 32'h8, 32'h002081B3, 0));
    vecs.push_back(mk(0, 0,     0, 0, 0, 0, 1, 1, 32'hC, 32'h00000013, 0));
    vecs.push_back(mk(0, 0,     0, 0, 0, 0, 1, 0, 0, 0, 0));
    // Faulting PCs
    vecs.push_back(mk(1, 32'h2,    0, 0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 32'h1000, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 32'h8,    0, 0, 0, 0, 1, 1, 32'h2, NOP, 1));
    vecs.push_back(mk(0, 0,        0, 0, 0, 0, 1, 1, 32'h1000, NOP, 1));
    vecs.push_back(mk(0, 0,        0, 0, 0, 0, 1, 1, 32'h8, 32'h002081B3, 0));
    vecs.push_back(mk(0, 0,        0, 0, 0, 0, 1, 0, 0, 0, 0));
    // Loader write then read of the same word
    vecs.push_back(mk(1, 32'h14, 0, 1, 32'h14, 32'hDEADBEEF, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 32'h14, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0,      0, 0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0,      0, 0, 0, 0, 1, 1, 32'h14, 32'hDEADBEEF, 0));
    vecs.push_back(mk(0, 0,      0, 0, 0, 0, 1, 0, 0, 0, 0));
    // Flush one cycle after the second accept
    vecs.push_back(mk(1, 32'h0,  0, 0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 32'h4,  0, 0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 32'h40, 1, 0, 0, 0, 0, 1, 32'h0, 32'h00500093, 0));
    vecs.push_back(mk(1, 32'h40, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0,      0, 0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0,      0, 0, 0, 0, 1, 1, 32'h40, 32'h12345678, 0));
    vecs.push_back(mk(0, 0,      0, 0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0,      0, 0, 0, 0, 1, 0, 0, 0, 0));

    idleInputs();
    rst = 1;
    @(negedge clk);

    // Preload all of memory with random words while in reset.
    for (int i = 0; i < DEPTH_WORDS; i++) begin
      ld_we = 1; ld_addr = 32'(i) << 2; ld_data = $urandom;
      step();
    end
    ld_we = 0;
    step();
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data",  rsp_data, 32'd0);
    chk("rst_rsp_addr",  rsp_addr, 32'd0);
    chk("rst_rsp_fault", 32'(rsp_fault), 32'd0);
    rst = 0;
    step();

    // Table-driven directed vectors
    for (int i = 0; i < vecs.size(); i++) begin
      req_valid = vecs[i].rv; req_addr = vecs[i].ra; rsp_ready = vecs[i].rr;
      flush = vecs[i].fl; ld_we = vecs[i].we; ld_addr = vecs[i].la; ld_data = vecs[i].ld;
      #1;
      chk($sformatf("v%0d_req_ready", i), 32'(req_ready), 32'(vecs[i].eRdy));
      chk($sformatf("v%0d_rsp_valid", i), 32'(rsp_valid), 32'(vecs[i].eVld));
      if (vecs[i].eVld) begin
        chk($sformatf("v%0d_rsp_addr", i),  rsp_addr, vecs[i].eAddr);
        chk($sformatf("v%0d_rsp_data", i),  rsp_data, vecs[i].eData);
        chk($sformatf("v%0d_rsp_fault", i), 32'(rsp_fault), 32'(vecs[i].eFault));
      end
      step();
    end
    idleInputs();

    // Backpressure: only FIFO_DEPTH requests get in, output held stable.
    accCnt = 0;
    rsp_ready = 0;
    for (int i = 0; i < 8; i++) begin
      req_valid = 1; req_addr = 32'(i) << 2;
      #1;
      chk("bp_req_ready", 32'(req_ready), 32'(i < FIFO_DEPTH));
      if (req_ready) accCnt++;
      if (i >= LATENCY) chk("bp_hold_data", rsp_data, 32'h00500093);
      step();
    end
    chk("bp_accepted", 32'(accCnt), 32'(FIFO_DEPTH));
    req_valid = 0; rsp_ready = 1;
    for (int j = 0; j < FIFO_DEPTH; j++) begin
      #1;
      chk("bp_drain_valid", 32'(rsp_valid), 32'd1);
      chk("bp_drain_addr",  rsp_addr, 32'(j) << 2);
      step();
    end
    #1;
    chk("bp_empty", 32'(rsp_valid), 32'd0);
    req_valid = 1; req_addr = 32'h8;
    #1;
    chk("bp_resume", 32'(req_ready), 32'd1);
    step();
    req_valid = 0;
    for (int i = 0; i < 4; i++) step();

    // Reset with three requests outstanding.
    rsp_ready = 0;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1; req_addr = 32'(i) << 2;
      step();
    end
    req_valid = 0;
    step();
    #1;
    held = rsp_data;
    chk("pre_rst_valid", 32'(rsp_valid), 32'd1);
    chk("pre_rst_data", held, 32'h00500093);
    rst = 1;
    step();
    rst = 0; rsp_ready = 1;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("post_rst_valid", 32'(rsp_valid), 32'd0);
      step();
    end

`ifdef IMEM_PARITY_EN
    // Parity error injected on load of word 0x10.
    ld_we = 1; ld_addr = 32'h10; ld_data = 32'hCAFEF00D; ld_perr_inj = 1;
    step();
    ld_we = 0; ld_perr_inj = 0;
    req_valid = 1; req_addr = 32'h10;
    step();
    req_valid = 0;
    step();
    #1;
    chk("par_valid", 32'(rsp_valid), 32'd1);
    chk("par_fault", 32'(rsp_fault), 32'd1);
    chk("par_data",  rsp_data, NOP);
    step();
    step();
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      rst       = ($urandom_range(0, 499) == 0);
      flush     = ($urandom_range(0, 39) == 0);
      ld_we     = ($urandom_range(0, 11) == 0);
      ld_addr   = ($urandom_range(0, 19) == 0) ? (32'h1000 + 32'($urandom_range(0, 255)))
                                               : {22'd0, 8'($urandom_range(0, 63)), 2'($urandom)};
      ld_data   = $urandom;
`ifdef IMEM_PARITY_EN
      ld_perr_inj = ($urandom_range(0, 7) == 0);
`endif
      req_valid = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 9))
        0:       req_addr = {22'd0, 8'($urandom_range(0, 63)), 2'($urandom_range(1, 3))};
        1:       req_addr = 32'h1000 + (32'($urandom_range(0, 1023)) << 2);
        default: req_addr = 32'($urandom_range(0, 63)) << 2;
      endcase
      rsp_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    idleInputs();
    for (int i = 0; i < 10; i++) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
